// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Two-source writeback arbiter in front of a single register-file write port.
// Source 0 carries ALU results, source 1 carries load results. Each cycle at
// most one source is accepted. The accepted beat is registered and presented
// on the writeback outputs one cycle later. Writes to x0 are accepted but
// produce no writeback valid.
//
// Optional feature (macro WRITEBACK_ARBITER_ROUND_ROBIN_EN):
//   defined   - conflicts go to the source not granted most recently
//   undefined - conflicts always go to source 1 (load); no last-grant state
//
// Ports:
//   i_Clock          system clock, rising-edge active
//   i_Reset          synchronous active-high reset, wins over i_Stall
//   i_Valid0/1       source request
//   i_Data0/1        32-bit result payload
//   i_Rd0/1          5-bit destination register
//   o_Ready0/1       combinational per-source accept
//   i_Stall          register-file port busy, freezes the output stage
//   o_WbValid        registered writeback valid
//   o_WbData/o_WbRd  registered writeback payload and destination
//   o_Select         registered index of the source held in o_WbData
//   o_ConflictCount  saturating count of unstalled cycles with both sources valid

module writeback_arbiter (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Valid0,
    input  logic [31:0] i_Data0,
    input  logic [4:0]  i_Rd0,
    input  logic        i_Valid1,
    input  logic [31:0] i_Data1,
    input  logic [4:0]  i_Rd1,
    output logic        o_Ready0,
    output logic        o_Ready1,
    input  logic        i_Stall,
    output logic        o_WbValid,
    output logic [31:0] o_WbData,
    output logic [4:0]  o_WbRd,
    output logic        o_Select,
    output logic [15:0] o_ConflictCount
);

    logic        r_WbValid;
    logic [31:0] r_WbData;
    logic [4:0]  r_WbRd;
    logic        r_Select;
    logic [15:0] r_ConflictCount;

    logic        w_Open;
    logic        w_Both;
    logic        w_Pick1;
    logic        w_Grant0;
    logic        w_Grant1;
    logic        w_Grant;
    logic [31:0] w_SelData;
    logic [4:0]  w_SelRd;
    logic        w_Conflict;

    // Transfers are only possible when neither reset nor stall holds the stage.
    assign w_Open = ~i_Reset & ~i_Stall;
    assign w_Both = i_Valid0 & i_Valid1;

`ifdef WRITEBACK_ARBITER_ROUND_ROBIN_EN
    // Index of the most recently granted source; resets to 1 so that
    // source 0 wins the first conflict.
    logic r_LastGrant;

    assign w_Pick1 = w_Both ? ~r_LastGrant : i_Valid1;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_LastGrant <= 1'b1;
        end else if (w_Grant) begin
            r_LastGrant <= w_Grant1;
        end
    end
`else
    // Fixed priority: loads win every conflict.
    assign w_Pick1 = i_Valid1;
`endif

    assign w_Grant1  = w_Open & i_Valid1 & w_Pick1;
    assign w_Grant0  = w_Open & i_Valid0 & ~w_Pick1;
    assign w_Grant   = w_Grant0 | w_Grant1;
    assign w_SelData = w_Grant1 ? i_Data1 : i_Data0;
    assign w_SelRd   = w_Grant1 ? i_Rd1 : i_Rd0;

    assign w_Conflict = w_Open & w_Both;

    assign o_Ready0 = w_Grant0;
    assign o_Ready1 = w_Grant1;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_WbValid       <= 1'b0;
            r_WbData        <= 32'h0;
            r_WbRd          <= 5'h0;
            r_Select        <= 1'b0;
            r_ConflictCount <= 16'h0;
        end else if (!i_Stall) begin
            if (w_Grant) begin
                // An x0 destination is consumed without a writeback.
                r_WbValid <= (w_SelRd != 5'h0);
                r_WbData  <= w_SelData;
                r_WbRd    <= w_SelRd;
                r_Select  <= w_Grant1;
            end else begin
                r_WbValid <= 1'b0;
            end
            if (w_Conflict && (r_ConflictCount != 16'hFFFF)) begin
                r_ConflictCount <= r_ConflictCount + 16'h1;
            end
        end
    end

    assign o_WbValid       = r_WbValid;
    assign o_WbData        = r_WbData;
    assign o_WbRd          = r_WbRd;
    assign o_Select        = r_Select;
    assign o_ConflictCount = r_ConflictCount;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a reference model tracks the
// expected writeback beat, grant policy and conflict count, and a checker
// compares every output on each falling edge. Directed sequences add
// hand-computed literal expectations.

module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        v0;
    logic [31:0] d0;
    logic [4:0]  rd0;
    logic        v1;
    logic [31:0] d1;
    logic [4:0]  rd1;
    logic        stall;
    logic        rdy0;
    logic        rdy1;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        sel;
    logic [15:0] cnt;

    int n_checks;
    int n_errors;
    bit chk_en;

    writeback_arbiter dut (
        .i_Clock         (clk),
        .i_Reset         (rst),
        .i_Valid0        (v0),
        .i_Data0         (d0),
        .i_Rd0           (rd0),
        .i_Valid1        (v1),
        .i_Data1         (d1),
        .i_Rd1           (rd1),
        .o_Ready0        (rdy0),
        .o_Ready1        (rdy1),
        .i_Stall         (stall),
        .o_WbValid       (wb_valid),
        .o_WbData        (wb_data),
        .o_WbRd          (wb_rd),
        .o_Select        (sel),
        .o_ConflictCount (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WRITEBACK_ARBITER_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    // Reference model state.
    bit          m_valid;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    bit          m_sel;
    int          m_cnt;
    int          m_last;   // source granted most recently

    // Which source the rules say wins this cycle: -1 none, else 0 or 1.
    function automatic int winner();
        if (rst || stall) return -1;
        if (v0 && v1) begin
            if (RoundRobin) return (m_last == 0) ? 1 : 0;
            return 1;
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int w;
        w = winner();
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_rd    <= 5'h0;
            m_sel   <= 1'b0;
            m_cnt   <= 0;
            m_last  <= 1;
        end else if (!stall) begin
            if (v0 && v1) m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (w == 0) begin
                m_valid <= (rd0 != 0);
                m_data  <= d0;
                m_rd    <= rd0;
                m_sel   <= 1'b0;
                m_last  <= 0;
            end else if (w == 1) begin
                m_valid <= (rd1 != 0);
                m_data  <= d1;
                m_rd    <= rd1;
                m_sel   <= 1'b1;
                m_last  <= 1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        if (chk_en) begin
            w = winner();
            check("ready0", {31'h0, rdy0}, {31'h0, w == 0});
            check("ready1", {31'h0, rdy1}, {31'h0, w == 1});
            check("wb_valid", {31'h0, wb_valid}, {31'h0, m_valid});
            check("wb_data", wb_data, m_data);
            check("wb_rd", {27'h0, wb_rd}, {27'h0, m_rd});
            check("select", {31'h0, sel}, {31'h0, m_sel});
            check("conflict_count", {16'h0, cnt}, m_cnt[31:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        stall = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic first_sel;
        n_checks = 0;
        n_errors = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        v0 = 1'b0; d0 = 32'h0; rd0 = 5'h0;
        v1 = 1'b0; d1 = 32'h0; rd1 = 5'h0;
        stall = 1'b0;
        step();
        chk_en = 1'b1;
        step();

        // Reset state, checked while reset is still asserted.
        check("reset_valid", {31'h0, wb_valid}, 32'h0);
        check("reset_count", {16'h0, cnt}, 32'h0);
        rst = 1'b0;

        // Single ALU beat.
        v0 = 1'b1; d0 = 32'hDEADBEEF; rd0 = 5'd5;
        step();
        check("single_valid", {31'h0, wb_valid}, 32'h1);
        check("single_data", wb_data, 32'hDEADBEEF);
        check("single_rd", {27'h0, wb_rd}, 32'd5);
        check("single_sel", {31'h0, sel}, 32'h0);
        v0 = 1'b0;
        step();
        check("idle_valid_drop", {31'h0, wb_valid}, 32'h0);
        check("idle_data_hold", wb_data, 32'hDEADBEEF);

        // Conflict: each source drops valid once served.
        do_reset();
        v0 = 1'b1; d0 = 32'hA; rd0 = 5'd1;
        v1 = 1'b1; d1 = 32'hB; rd1 = 5'd2;
        first_sel = RoundRobin ? 1'b0 : 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic a0;
            logic a1;
            #1;
            a0 = rdy0;
            a1 = rdy1;
            step();
            if (a0) v0 = 1'b0;
            if (a1) v1 = 1'b0;
            if (i == 0) begin
                check("conflict_first_sel", {31'h0, sel}, {31'h0, first_sel});
                check("conflict_first_data", wb_data, first_sel ? 32'hB : 32'hA);
            end
            if (i == 1) begin
                check("conflict_second_sel", {31'h0, sel}, {31'h0, ~first_sel});
                check("conflict_second_valid", {31'h0, wb_valid}, 32'h1);
            end
        end
        check("conflict_count_one", {16'h0, cnt}, 32'h1);

        // Stall freezes the output stage; the pending beat appears once.
        do_reset();
        v0 = 1'b1; d0 = 32'h11; rd0 = 5'd3;
        step();
        d0 = 32'h22; rd0 = 5'd4;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready0", {31'h0, rdy0}, 32'h0);
            step();
            check("stall_hold_data", wb_data, 32'h11);
            check("stall_hold_valid", {31'h0, wb_valid}, 32'h1);
        end
        stall = 1'b0;
        #1;
        check("release_ready0", {31'h0, rdy0}, 32'h1);
        step();
        v0 = 1'b0;
        check("release_data", wb_data, 32'h22);
        check("release_rd", {27'h0, wb_rd}, 32'd4);
        step();
        check("release_once", {31'h0, wb_valid}, 32'h0);

        // x0 write is accepted and dropped.
        v1 = 1'b1; d1 = 32'h1234; rd1 = 5'd0;
        #1;
        check("x0_ready1", {31'h0, rdy1}, 32'h1);
        step();
        v1 = 1'b0;
        check("x0_dropped", {31'h0, wb_valid}, 32'h0);

        // Withdrawn request during stall, then a mixed pattern.
        stall = 1'b1; v1 = 1'b1; d1 = 32'h77; rd1 = 5'd9;
        step();
        v1 = 1'b0;
        step();
        stall = 1'b0;
        v0 = 1'b1; d0 = 32'h88; rd0 = 5'd10;
        v1 = 1'b1;
        step();
        stall = 1'b1;
        step();
        stall = 1'b0;
        step();
        v0 = 1'b0; v1 = 1'b0;
        step();

        // Reset during a stall with a valid beat held.
        do_reset();
        v0 = 1'b1; d0 = 32'h55; rd0 = 5'd7;
        step();
        v0 = 1'b0;
        stall = 1'b1;
        step();
        check("pre_reset_valid", {31'h0, wb_valid}, 32'h1);
        rst = 1'b1;
        #1;
        check("reset_ready_low", {30'h0, rdy0, rdy1}, 32'h0);
        step();
        check("mid_reset_valid", {31'h0, wb_valid}, 32'h0);
        check("mid_reset_data", wb_data, 32'h0);
        check("mid_reset_rd", {27'h0, wb_rd}, 32'h0);
        check("mid_reset_sel", {31'h0, sel}, 32'h0);
        rst = 1'b0;
        stall = 1'b0;

        // Saturation of the conflict counter.
        do_reset();
        v0 = 1'b1; d0 = 32'h1; rd0 = 5'd1;
        v1 = 1'b1; d1 = 32'h2; rd1 = 5'd2;
        for (int i = 0; i < 65534; i++) step();
        check("count_fffe", {16'h0, cnt}, 32'hFFFE);
        for (int i = 0; i < 3; i++) step();
        check("count_sat", {16'h0, cnt}, 32'hFFFF);
        step();
        check("count_stays", {16'h0, cnt}, 32'hFFFF);
        v0 = 1'b0; v1 = 1'b0;
        step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
- REQ-001: Clock and reset SHALL be the first two ports: i_Clock, single clock, all state updates on its rising edge; i_Reset, synchronous, active-high.
- REQ-002: i_Clock  input  1  system clock.
- REQ-003: i_Reset  input  1  synchronous active-high reset.
- REQ-004: i_Valid0 / i_Data0 / i_Rd0  input  1/32/5  source 0 (ALU result) request, payload, destination register.
- REQ-005: i_Valid1 / i_Data1 / i_Rd1  input  1/32/5  source 1 (load result) request, payload, destination register.
- REQ-006: o_Ready0 / o_Ready1  output  1  per-source accept; a transfer occurs when valid and ready are both high at a rising edge.
- REQ-007: i_Stall  input  1  register-file port busy; freezes the output stage.
- REQ-008: o_WbValid / o_WbData / o_WbRd  output  1/32/5  registered writeback beat.
- REQ-009: o_Select  output  1  registered index of the source in o_WbData; drives the select of the downstream 2:1 result multiplexer.
- REQ-010: o_ConflictCount  output  16  saturating count of cycles where both sources were valid and i_Stall was low.

Function
- REQ-011: o_Ready0/o_Ready1 SHALL be combinational, at most one high per cycle, both low while i_Stall is high.
- REQ-012: With only one source valid and i_Stall low, that source SHALL be granted.
- REQ-013: With both valid and i_Stall low, the grant SHALL follow the arbitration policy of REQ-024/REQ-025; the loser keeps valid and payload stable and is served in a later cycle.
- REQ-014: A granted beat SHALL appear on o_WbData/o_WbRd/o_Select exactly one cycle after the accepting edge (latency 1).
- REQ-015: o_WbValid SHALL be 1 in the cycle after a grant, except a granted beat with Rd = 0 is consumed and o_WbValid = 0 (x0 writes dropped).
- REQ-016: With i_Stall low and no grant, o_WbValid SHALL drop to 0 next cycle; o_WbData, o_WbRd and o_Select hold their last values.
- REQ-017: With i_Stall high, all output registers, the last-grant state and o_ConflictCount SHALL hold; no beat is lost or duplicated.
- REQ-018: o_ConflictCount SHALL increment by 1 per qualifying cycle and saturate at 16'hFFFF, with no wrap.
- REQ-019: Valid deasserting without a grant SHALL be legal; the request is simply withdrawn.

Reset
- REQ-020: An asserted i_Reset SHALL drive at the next edge: o_WbValid=0, o_WbData=32'h0, o_WbRd=5'h0, o_Select=0, o_ConflictCount=0, last-grant=1 (source 0 wins the first conflict).
- REQ-021: While i_Reset is high, o_Ready0 and o_Ready1 SHALL be 0 and no transfer occurs.
- REQ-022: A reset asserted mid-stall or mid-conflict SHALL discard the pending output beat; reset SHALL take priority over i_Stall.
- REQ-023: The first grant SHALL be possible in the first cycle after i_Reset deasserts.

Configuration
- REQ-024: With WRITEBACK_ARBITER_ROUND_ROBIN_EN defined, conflicts SHALL grant the source not granted most recently; last-grant updates only on a grant.
- REQ-025: Without WRITEBACK_ARBITER_ROUND_ROBIN_EN, conflicts SHALL always grant source 1 (load), and the last-grant register SHALL NOT be implemented.

Verification
- REQ-026: Reset, then Valid0=1, Data0=32'hDEADBEEF, Rd0=5 for one cycle -> next cycle o_WbValid=1, o_WbData=32'hDEADBEEF, o_WbRd=5, o_Select=0.
- REQ-027: Both valid for 4 cycles (Data0=32'hA, Data1=32'hB, distinct Rd), round-robin build -> grants 0,1 with o_Select 0 then 1, o_ConflictCount=1; fixed build -> source 1 first, o_ConflictCount=1.
- REQ-028: Beat accepted, then i_Stall=1 for 3 cycles with Valid0=1 -> outputs frozen and o_Ready0=0 throughout; after release the pending beat appears once, one cycle later.
- REQ-029: Valid1=1, Rd1=0, Data1=32'h1234 -> o_Ready1=1 and next cycle o_WbValid=0.
- REQ-030: Force o_ConflictCount to 16'hFFFE, then hold both valid for 3 unstalled cycles -> count reads 16'hFFFF and stays there.
- REQ-031: i_Reset pulsed for one cycle during stall with o_WbValid=1 -> next cycle all outputs hold the REQ-020 values.
